// File: rtl/mc_inst_fifo.sv
// ============================================================================
// mc_inst_fifo: per-channel instruction FIFOs with credit-gated round-robin
// output arbitration. Optional occupancy port: define MC_INST_FIFO_OCC_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_inst_fifo #(
    parameter int WIDTH      = 14,
    parameter int DEPTH      = 16,
    parameter int NCH        = 4,
    parameter int PE_BASE    = 0,
    parameter int IDW        = 4,
    parameter int CREDIT_MAX = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH-1:0]           in_valid,
    output logic [NCH-1:0]           in_ready,
    input  logic [NCH*WIDTH-1:0]     in_data,
    input  logic [NCH-1:0]           ack_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH+IDW-1:0]     out_data
`ifdef MC_INST_FIFO_OCC_EN
    ,
    output logic [NCH*($clog2(DEPTH)+1)-1:0] occ
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(CREDIT_MAX + 1);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   w_elig;
    logic [NCH-1:0]   w_pop;
    logic [WIDTH-1:0] w_head [NCH];
    logic [SW-1:0]    w_sel;
    logic             w_any;
    logic             w_xfer;
    logic [SW-1:0]    rr_q;
    logic [SW-1:0]    sel_q;
    logic             lock_q;

    assign w_xfer = out_valid & out_ready;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [PW-1:0]    wp_q, rp_q, wp_d, rp_d;
            logic [PW-1:0]    w_count;
            logic [CW-1:0]    cred_q, cred_d;
            logic             w_push;
            logic             w_dec;

            assign w_count     = wp_q - rp_q;
            assign in_ready[c] = (w_count != PW'(DEPTH));
            assign w_push      = in_valid[c] & in_ready[c];
            assign w_head[c]   = mem_q[rp_q[AW-1:0]];
            assign w_pop[c]    = w_xfer & (w_sel == SW'(c));
            // Tag 2'b00 marks a new-ifmap packet, which consumes one ack credit.
            assign w_elig[c]   = (w_count != '0) &&
                                 ((w_head[c][1:0] != 2'b00) || (cred_q != '0));
            assign w_dec       = w_pop[c] & (w_head[c][1:0] == 2'b00);
            assign wp_d        = wp_q + {{(PW-1){1'b0}}, w_push};
            assign rp_d        = rp_q + {{(PW-1){1'b0}}, w_pop[c]};

            always_comb begin
                cred_d = cred_q;
                if (ack_valid[c] && !w_dec) begin
                    if (cred_q != CW'(CREDIT_MAX)) begin
                        cred_d = cred_q + CW'(1);
                    end
                end else if (w_dec && !ack_valid[c]) begin
                    cred_d = cred_q - CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (w_push) begin
                    mem_q[wp_q[AW-1:0]] <= in_data[c*WIDTH +: WIDTH];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wp_q   <= '0;
                    rp_q   <= '0;
                    cred_q <= '0;
                end else begin
                    wp_q   <= wp_d;
                    rp_q   <= rp_d;
                    cred_q <= cred_d;
                end
            end

`ifdef MC_INST_FIFO_OCC_EN
            logic [PW-1:0] occ_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    occ_q <= '0;
                end else begin
                    occ_q <= wp_d - rp_d;
                end
            end
            assign occ[c*PW +: PW] = occ_q;
`endif
        end
    endgenerate

    function automatic logic [SW-1:0] rr_idx(input logic [SW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NCH;
        return SW'(s);
    endfunction

    // Scan from farthest to nearest so the channel right after rr_q wins.
    always_comb begin
        w_sel = sel_q;
        w_any = lock_q;
        if (!lock_q) begin
            w_sel = '0;
            for (int k = NCH; k >= 1; k--) begin
                if (w_elig[rr_idx(rr_q, k)]) begin
                    w_sel = rr_idx(rr_q, k);
                    w_any = 1'b1;
                end
            end
        end
    end

    assign out_valid = w_any;
    assign out_data  = w_any ? {w_head[w_sel], IDW'(PE_BASE + int'(w_sel))} : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= 1'b0;
            sel_q  <= '0;
            rr_q   <= SW'(NCH - 1);
        end else begin
            sel_q <= w_sel;
            if (w_xfer) begin
                lock_q <= 1'b0;
                rr_q   <= w_sel;
            end else if (w_any) begin
                lock_q <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_inst_fifo.sv
// ============================================================================
// tb_mc_inst_fifo: scoreboard bench with a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_inst_fifo;

    localparam int WIDTH      = 14;
    localparam int DEPTH      = 16;
    localparam int NCH        = 4;
    localparam int PE_BASE    = 0;
    localparam int IDW        = 4;
    localparam int CREDIT_MAX = 3;
    localparam int PW         = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       ack_valid;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH+IDW-1:0] out_data;
`ifdef MC_INST_FIFO_OCC_EN
    logic [NCH*PW-1:0]    occ;
`endif

    mc_inst_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH),
        .PE_BASE(PE_BASE), .IDW(IDW), .CREDIT_MAX(CREDIT_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ack_valid(ack_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef MC_INST_FIFO_OCC_EN
        , .occ(occ)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: queue per channel, integer credits, last grant, lock.
    logic [WIDTH-1:0] mq [NCH][$];
    int mcred [NCH];
    int mlast;
    bit mlocked;
    int mlock_ch;

    int errors = 0;
    int checks = 0;
    int dut_grants [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void msel(output bit v, output int ch);
        logic [WIDTH-1:0] h;
        v  = 1'b0;
        ch = 0;
        if (mlocked) begin
            v  = 1'b1;
            ch = mlock_ch;
            return;
        end
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (mlast + k) % NCH;
            if (mq[c].size() > 0) begin
                h = mq[c][0];
                if (h[1:0] != 2'b00 || mcred[c] > 0) begin
                    v  = 1'b1;
                    ch = c;
                    return;
                end
            end
        end
    endfunction

    task automatic mreset();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            mcred[c] = 0;
        end
        mlast    = NCH - 1;
        mlocked  = 1'b0;
        mlock_ch = 0;
    endtask

    task automatic mstep();
        bit v;
        int ch;
        bit xfer;
        bit acc [NCH];
        logic [WIDTH-1:0] h;
        if (reset) begin
            mreset();
            return;
        end
        msel(v, ch);
        xfer = v && out_ready;
        for (int c = 0; c < NCH; c++) begin
            bit dec;
            acc[c] = in_valid[c] && (mq[c].size() < DEPTH);
            dec = 1'b0;
            if (xfer && ch == c) begin
                h   = mq[c][0];
                dec = (h[1:0] == 2'b00);
            end
            if (ack_valid[c] && !dec) begin
                if (mcred[c] < CREDIT_MAX) mcred[c]++;
            end else if (dec && !ack_valid[c]) begin
                mcred[c]--;
            end
        end
        if (xfer) begin
            void'(mq[ch].pop_front());
            mlast   = ch;
            mlocked = 1'b0;
        end else if (v) begin
            mlocked  = 1'b1;
            mlock_ch = ch;
        end
        for (int c = 0; c < NCH; c++) begin
            if (acc[c]) mq[c].push_back(in_data[c*WIDTH +: WIDTH]);
        end
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk);
            mstep();
        end
    end

    // Monitor: compare DUT outputs against the model each cycle.
    initial begin
        @(posedge clk);
        forever begin
            bit v;
            int ch;
            logic [NCH-1:0] exp_rdy;
            logic [WIDTH+IDW-1:0] exp_data;
            @(negedge clk);
            msel(v, ch);
            for (int c = 0; c < NCH; c++) exp_rdy[c] = (mq[c].size() != DEPTH);
            exp_data = v ? {mq[ch][0], IDW'(PE_BASE + ch)} : '0;
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(v));
            chk("out_data", 32'(out_data), 32'(exp_data));
`ifdef MC_INST_FIFO_OCC_EN
            for (int c = 0; c < NCH; c++) begin
                chk("occ", 32'(occ[c*PW +: PW]), 32'(mq[c].size()));
            end
`endif
            if (out_valid && out_ready) dut_grants.push_back(int'(out_data[IDW-1:0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int exp_g [6] = '{0, 1, 3, 0, 1, 3};
    logic [WIDTH+IDW-1:0] held;

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        ack_valid = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'hF);

        // Single push on ch2 appears the next cycle.
        out_ready = 1'b1;
        in_valid = 4'b0100;
        in_data[2*WIDTH +: WIDTH] = 14'h0005;
        tick();
        in_valid = '0;
        chk("ch2_valid", 32'(out_valid), 32'd1);
        chk("ch2_data", 32'(out_data), 32'h00052);
        tick();

        // Tag-00 packet waits for an ack credit.
        in_valid = 4'b0001;
        in_data[0 +: WIDTH] = 14'h0004;
        tick();
        in_valid = '0;
        tick();
        tick();
        chk("tag_blocked", 32'(out_valid), 32'd0);
        ack_valid = 4'b0001;
        tick();
        ack_valid = '0;
        chk("tag_released", 32'(out_valid), 32'd1);
        chk("tag_data", 32'(out_data), 32'h00040);
        tick();
        in_valid = 4'b0001;
        in_data[0 +: WIDTH] = 14'h0008;
        tick();
        in_valid = '0;
        tick();
        chk("credit_zero", 32'(out_valid), 32'd0);
        ack_valid = 4'b0001;
        tick();
        ack_valid = '0;
        tick();
        tick();

        // Fill ch1, reject the 17th, drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 4'b0010;
            in_data[1*WIDTH +: WIDTH] = 14'((i << 2) | 1);
            tick();
        end
        chk("ch1_full", 32'(in_ready[1]), 32'd0);
        in_data[1*WIDTH +: WIDTH] = 14'h3FFD;
        tick();
        in_valid = '0;
        dut_grants.delete();
        out_ready = 1'b1;
        repeat (DEPTH) tick();
        chk("drain_count", 32'(dut_grants.size()), 32'(DEPTH));
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Round-robin across ch0, ch1, ch3.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 4'b1011;
            for (int c = 0; c < NCH; c++) in_data[c*WIDTH +: WIDTH] = 14'(((c * 16 + k) << 2) | 2);
            tick();
        end
        in_valid = '0;
        dut_grants.delete();
        out_ready = 1'b1;
        repeat (6) tick();
        chk("rr_count", 32'(dut_grants.size()), 32'd6);
        for (int i = 0; i < 6 && i < dut_grants.size(); i++) chk("rr_order", 32'(dut_grants[i]), 32'(exp_g[i]));

        // Output held stable under backpressure while ch3 fills.
        out_ready = 1'b0;
        in_valid = 4'b0001;
        in_data[0 +: WIDTH] = 14'h1231;
        tick();
        held = out_data;
        chk("hold_first", 32'(held), 32'h12310);
        for (int i = 0; i < 5; i++) begin
            in_valid = 4'b1000;
            in_data[3*WIDTH +: WIDTH] = 14'(($urandom << 2) | 3);
            tick();
            chk("hold_stable", 32'(out_data), 32'(held));
        end
        in_valid = '0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("hold_drained", 32'(out_valid), 32'd0);

        // Credit saturation: 5 acks, 4 tag packets, only 3 emitted.
        do_reset();
        out_ready = 1'b0;
        ack_valid = 4'b0001;
        repeat (5) tick();
        ack_valid = '0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 4'b0001;
            in_data[0 +: WIDTH] = 14'((i + 1) << 4);
            tick();
        end
        in_valid = '0;
        dut_grants.delete();
        out_ready = 1'b1;
        repeat (8) tick();
        chk("sat_grants", 32'(dut_grants.size()), 32'd3);
        chk("sat_stall", 32'(out_valid), 32'd0);

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'b0110;
            in_data[1*WIDTH +: WIDTH] = 14'(($urandom << 2) | 1);
            in_data[2*WIDTH +: WIDTH] = 14'(($urandom << 2) | 2);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = '0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'hF);
`ifdef MC_INST_FIFO_OCC_EN
        chk("midrst_occ", 32'(occ), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            in_valid = 4'($urandom);
            for (int c = 0; c < NCH; c++) in_data[c*WIDTH +: WIDTH] = 14'($urandom);
            for (int c = 0; c < NCH; c++) ack_valid[c] = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            else reset = 1'b0;
            tick();
        end
        reset = 1'b0;
        in_valid = '0;
        ack_valid = '0;
        out_ready = 1'b1;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
